// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding unit for the 5-stage ARM pipe; optional HAZARD_PERF_EN adds saturating perf counters.
// Latency: forwarding/stall/flush combinational, mem-stall FSM holds all stages MEM_LAT-1 cycles per M access.
module hazard_unit_mc #(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 2,
    parameter int MEM_LAT    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] RA_D,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] RA_E,
    input  logic [REG_ADDR_W-1:0]         WA_E,
    input  logic [REG_ADDR_W-1:0]         WA_M,
    input  logic [REG_ADDR_W-1:0]         WA_W,
    input  logic                          RegWriteE,
    input  logic                          RegWriteM,
    input  logic                          RegWriteW,
    input  logic                          MemtoRegE,
    input  logic                          MemReqM,
    input  logic                          PCSrcD,
    input  logic                          PCSrcE,
    input  logic                          PCSrcM,
    input  logic                          PCSrcW,
    input  logic                          BranchTakenE,
    output logic [2*NUM_SRC-1:0]          ForwardE,
    output logic                          StallF,
    output logic                          StallD,
    output logic                          StallE,
    output logic                          StallM,
    output logic                          FlushD,
    output logic                          FlushE,
    output logic                          FlushW
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]                   PerfLdStall,
    output logic [31:0]                   PerfMemStall,
    output logic [31:0]                   PerfFlush
`endif
);

    localparam logic [REG_ADDR_W-1:0] R15 = '1;
    localparam int CNT_W = (MEM_LAT > 3) ? $clog2(MEM_LAT - 2) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LAT >= 3) ? (MEM_LAT - 3) : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic               mem_busy;
    logic               mem_stall;
    logic               ld_match;
    logic               ldr_stall;
    logic               pc_pend;
    logic [2*NUM_SRC-1:0] fwd;

    // PC reads never forward: R15 comes from the fetch path, not the result buses.
    always_comb begin
        fwd = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (RA_E[i*REG_ADDR_W +: REG_ADDR_W] != R15) begin
                if (RegWriteM && RA_E[i*REG_ADDR_W +: REG_ADDR_W] == WA_M)
                    fwd[2*i +: 2] = 2'b10;
                else if (RegWriteW && RA_E[i*REG_ADDR_W +: REG_ADDR_W] == WA_W)
                    fwd[2*i +: 2] = 2'b01;
            end
        end
    end

    always_comb begin
        ld_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (RA_D[i*REG_ADDR_W +: REG_ADDR_W] == WA_E && WA_E != R15)
                ld_match = 1'b1;
        end
    end

    assign ldr_stall = MemtoRegE & RegWriteE & ld_match;
    assign pc_pend   = PCSrcD | PCSrcE | PCSrcM;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // DONE always returns to IDLE so the same M instruction cannot retrigger.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        mem_busy  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MemReqM && MEM_LAT > 1) begin
                    mem_busy = 1'b1;
                    if (MEM_LAT == 2) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                mem_busy = 1'b1;
                if (cnt_q == '0)
                    state_nxt = ST_DONE;
                else
                    cnt_nxt = cnt_q - 1'b1;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign mem_stall = mem_busy & ~reset;

    always_comb begin
        ForwardE = fwd;
        StallF   = 1'b0;
        StallD   = 1'b0;
        StallE   = 1'b0;
        StallM   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        FlushW   = 1'b0;
        if (reset) begin
            ForwardE = '0;
            FlushD   = 1'b1;
            FlushE   = 1'b1;
            FlushW   = 1'b1;
        end else if (mem_stall) begin
            // Frozen E re-presents BranchTakenE in DONE, so no flush here.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = ldr_stall | pc_pend;
            StallD = ldr_stall;
            FlushD = pc_pend | PCSrcW | BranchTakenE;
            FlushE = ldr_stall | BranchTakenE;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            PerfLdStall  <= '0;
            PerfMemStall <= '0;
            PerfFlush    <= '0;
        end else begin
            if (ldr_stall && !mem_stall && !(&PerfLdStall))
                PerfLdStall <= PerfLdStall + 32'd1;
            if (mem_stall && !(&PerfMemStall))
                PerfMemStall <= PerfMemStall + 32'd1;
            if (FlushD && !(&PerfFlush))
                PerfFlush <= PerfFlush + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: four NUM_SRC=3 instances at MEM_LAT 1/3/4/5 sharing one stimulus.
module tb_hazard_unit_mc;

    localparam int AW = 4;
    localparam int NS = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NS*AW-1:0]  RA_D, RA_E;
    logic [AW-1:0]     WA_E, WA_M, WA_W;
    logic              RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemReqM;
    logic              PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;

    // index 0: MEM_LAT=1, 1: MEM_LAT=3, 2: MEM_LAT=4, 3: MEM_LAT=5
    logic [2*NS-1:0]   fwd [4];
    logic              stf [4], std [4], ste [4], stm [4], fld [4], fle [4], flw [4];
`ifdef HAZARD_PERF_EN
    logic [31:0]       p_ld [4], p_mem [4], p_fl [4];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef HAZARD_PERF_EN
    `define PERF_PORTS(k) , .PerfLdStall(p_ld[k]), .PerfMemStall(p_mem[k]), .PerfFlush(p_fl[k])
`else
    `define PERF_PORTS(k)
`endif

    `define DUT(name, lat, k) \
    hazard_unit_mc #(.REG_ADDR_W(AW), .NUM_SRC(NS), .MEM_LAT(lat)) name ( \
        .clk(clk), .reset(reset), .RA_D(RA_D), .RA_E(RA_E), .WA_E(WA_E), .WA_M(WA_M), .WA_W(WA_W), \
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), \
        .MemReqM(MemReqM), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW), \
        .BranchTakenE(BranchTakenE), .ForwardE(fwd[k]), .StallF(stf[k]), .StallD(std[k]), \
        .StallE(ste[k]), .StallM(stm[k]), .FlushD(fld[k]), .FlushE(fle[k]), .FlushW(flw[k]) `PERF_PORTS(k));

    `DUT(u_l1, 1, 0)
    `DUT(u_l3, 3, 1)
    `DUT(u_l4, 4, 2)
    `DUT(u_l5, 5, 3)

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven for the new cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RA_D = '0; RA_E = '0; WA_E = '0; WA_M = '0; WA_W = '0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; MemReqM = 0;
        PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0; BranchTakenE = 0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        cyc(); cyc();

        // Reset: forwarding/mem-request inputs active, outputs must still be the reset pattern.
        RA_E = {4'd15, 4'd3, 4'd2}; WA_M = 4'd3; RegWriteM = 1; MemReqM = 1; PCSrcD = 1;
        #1;
        chk("rst_fwd",   32'(fwd[2]), 32'h0);
        chk("rst_stallF", 32'(stf[2]), 32'h0);
        chk("rst_stallM", 32'(stm[2]), 32'h0);
        chk("rst_flushD", 32'(fld[2]), 32'h1);
        chk("rst_flushE", 32'(fle[2]), 32'h1);
        chk("rst_flushW", 32'(flw[2]), 32'h1);
        cyc();
        reset = 1'b0;
        clear_inputs();

        // Load-use on op1
        MemtoRegE = 1; RegWriteE = 1; WA_E = 4'd4; RA_D = {4'd0, 4'd4, 4'd0};
        #1;
        chk("ldu_stallF", 32'(stf[1]), 32'h1);
        chk("ldu_stallD", 32'(std[1]), 32'h1);
        chk("ldu_flushE", 32'(fle[1]), 32'h1);
        chk("ldu_flushD", 32'(fld[1]), 32'h0);
        chk("ldu_stallE", 32'(ste[1]), 32'h0);
        cyc();
        // R15 load destination never stalls
        WA_E = 4'd15; RA_D = {4'd0, 4'd15, 4'd0};
        #1;
        chk("ldu15_stallF", 32'(stf[1]), 32'h0);
        chk("ldu15_stallD", 32'(std[1]), 32'h0);
        chk("ldu15_flushE", 32'(fle[1]), 32'h0);
        cyc();
        clear_inputs();

        // MEM_LAT=3 access with a taken branch held in E
        MemReqM = 1; BranchTakenE = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("ml3_stallM_c%0d", i), 32'(stm[1]), (i < 2) ? 32'h1 : 32'h0);
            chk($sformatf("ml3_flushW_c%0d", i), 32'(flw[1]), (i < 2) ? 32'h1 : 32'h0);
            chk($sformatf("ml3_flushD_c%0d", i), 32'(fld[1]), (i < 2) ? 32'h0 : 32'h1);
            chk($sformatf("ml3_flushE_c%0d", i), 32'(fle[1]), (i < 2) ? 32'h0 : 32'h1);
            if (i == 0) begin
                chk("ml1_stallM", 32'(stm[0]), 32'h0);
                chk("ml1_flushD", 32'(fld[0]), 32'h1);
            end
            cyc();
        end
        clear_inputs();
`ifdef HAZARD_PERF_EN
        #1;
        chk("perf_ld",  p_ld[1],  32'd1);
        chk("perf_mem", p_mem[1], 32'd2);
`endif
        for (int i = 0; i < 4; i++) cyc();

        // Forwarding priority and R15 exclusion: op0=R2, op1=R3, op2=R15
        RA_E = {4'd15, 4'd3, 4'd2};
        WA_M = 4'd3; RegWriteM = 1; WA_W = 4'd3; RegWriteW = 1;
        #1; chk("fwd_m_over_w", 32'(fwd[2]), 32'b00_10_00);
        WA_W = 4'd2;
        #1; chk("fwd_mixed", 32'(fwd[2]), 32'b00_10_01);
        WA_M = 4'd15;
        #1; chk("fwd_r15_m", 32'(fwd[2]), 32'b00_00_01);
        WA_W = 4'd15;
        #1; chk("fwd_r15_w", 32'(fwd[2]), 32'b00_00_00);
        WA_W = 4'd2; RegWriteW = 0;
        #1; chk("fwd_nowrite", 32'(fwd[2]), 32'b00_00_00);
        clear_inputs();

        // PC-writing instructions
        PCSrcD = 1;
        #1;
        chk("pcD_stallF", 32'(stf[2]), 32'h1);
        chk("pcD_stallD", 32'(std[2]), 32'h0);
        chk("pcD_flushD", 32'(fld[2]), 32'h1);
        chk("pcD_flushE", 32'(fle[2]), 32'h0);
        PCSrcD = 0; PCSrcW = 1;
        #1;
        chk("pcW_stallF", 32'(stf[2]), 32'h0);
        chk("pcW_flushD", 32'(fld[2]), 32'h1);
        PCSrcW = 0;
        cyc();

        // MEM_LAT=4, request held: two back-to-back accesses
        MemReqM = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("ml4_stallE_c%0d", i), 32'(ste[2]), (i == 3 || i == 7) ? 32'h0 : 32'h1);
            chk($sformatf("ml4_flushW_c%0d", i), 32'(flw[2]), (i == 3 || i == 7) ? 32'h0 : 32'h1);
            cyc();
        end
        MemReqM = 0;
        for (int i = 0; i < 5; i++) cyc();

        // MEM_LAT=5: reset in WAIT, then a full restart
        MemReqM = 1;
        #1; chk("ml5_pre_c0", 32'(stf[3]), 32'h1);
        cyc();
        #1; chk("ml5_pre_c1", 32'(stf[3]), 32'h1);
        reset = 1'b1;
        #1;
        chk("ml5_rst_stallF", 32'(stf[3]), 32'h0);
        chk("ml5_rst_flushD", 32'(fld[3]), 32'h1);
        chk("ml5_rst_flushE", 32'(fle[3]), 32'h1);
        chk("ml5_rst_flushW", 32'(flw[3]), 32'h1);
        cyc();
        #1; chk("ml5_rst2_stallM", 32'(stm[3]), 32'h0);
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("ml5_stallM_c%0d", i), 32'(stm[3]), (i < 4) ? 32'h1 : 32'h0);
            cyc();
        end
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Parametrised hazard and forwarding unit for the 5-stage pipelined ARM core, successor to the fixed-function hazard unit. It compares register addresses directly instead of consuming precomputed match flags, and supports any operand count. It adds a multi-cycle data-memory stall FSM for `MEM_LAT` > 1. It drives forwarding selects to Execute and stall/flush controls to all pipeline registers.

## Interface
- `REG_ADDR_W`, 4: register address width; all-ones address is R15 (PC).
- `NUM_SRC`, 2: source operands per instruction (2 or 3; 3 = register-shifted operand).
- `MEM_LAT`, 1: data-memory access latency in cycles, ≥1.

- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `RA_D`  in  NUM_SRC*REG_ADDR_W: Decode source registers, operand i at `[i*REG_ADDR_W +: REG_ADDR_W]`.
- `RA_E`  in  NUM_SRC*REG_ADDR_W: Execute source registers, same packing.
- `WA_E`, `WA_M`, `WA_W`  in  REG_ADDR_W each: destination register in E/M/W.
- `RegWriteE`, `RegWriteM`, `RegWriteW`  in  1 each: register write enable per stage.
- `MemtoRegE`  in  1: E holds a load.
- `MemReqM`  in  1: M holds a load/store.
- `PCSrcD`, `PCSrcE`, `PCSrcM`, `PCSrcW`  in  1 each: PC-writing instruction in the stage.
- `BranchTakenE`  in  1: branch resolved taken in E.
- `ForwardE`  out  2*NUM_SRC: per-operand select, 00 register file, 01 ResultW, 10 ALUOutM.
- `StallF`, `StallD`, `StallE`, `StallM`  out  1 each: hold pipeline register.
- `FlushD`, `FlushE`, `FlushW`  out  1 each: bubble into stage.
- `PerfLdStall`, `PerfMemStall`, `PerfFlush`  out  32 each: only with `HAZARD_PERF_EN`.

## Operation
- Forwarding, per operand i, combinational:
  - 10 if `RA_E[i]==WA_M` and `RegWriteM`.
  - Else 01 if `RA_E[i]==WA_W` and `RegWriteW`.
  - Else 00.
  - M has priority over W.
  - R15 sources never forward.
- ldrStall: `MemtoRegE & RegWriteE` and any `RA_D[i]==WA_E`, with R15 excluded.
- pcPend: `PCSrcD|PCSrcE|PCSrcM`.
- Memory-stall FSM, states IDLE, WAIT, DONE, with a counter sized for `MEM_LAT`:
  - IDLE: if `MemReqM` and `MEM_LAT`>1, memStall=1. Go to DONE if `MEM_LAT`==2, else go to WAIT with cnt←`MEM_LAT`−3.
  - WAIT: memStall=1. If cnt==0 go to DONE, else cnt−1.
  - DONE: memStall=0. Unconditionally go to IDLE. This prevents retriggering on the same M instruction.
  - `MEM_LAT`==1: FSM stays in IDLE and memStall is constant 0.
- Outputs, when memStall=1:
  - `StallF`=`StallD`=`StallE`=`StallM`=1.
  - `FlushW`=1.
  - `FlushD`=`FlushE`=0. The frozen E re-presents `BranchTakenE` in DONE.
- Outputs, when memStall=0:
  - `StallF` = ldrStall|pcPend.
  - `StallD` = ldrStall.
  - `StallE`=`StallM`=`FlushW`=0.
  - `FlushD` = pcPend|`PCSrcW`|`BranchTakenE`.
  - `FlushE` = ldrStall|`BranchTakenE`.
- During reset:
  - FSM←IDLE, cnt←0.
  - All stalls 0, `FlushD`=`FlushE`=`FlushW`=1, `ForwardE`=0.

## Timing
- Forwarding, ldrStall and flush are combinational from inputs in the same cycle.
- The only state is the FSM/counter (plus perf counters).
- Memory stall sequence:
  - Stalls are asserted for exactly `MEM_LAT`−1 consecutive cycles, starting the first cycle `MemReqM` is seen in IDLE.
  - The M instruction advances at the end of the DONE cycle.
  - Back-to-back memory instructions each get `MEM_LAT`−1 stall cycles, separated by one DONE cycle.
- Reset asserted mid-WAIT: next cycle is IDLE; no stall is output while reset is high.

## Configuration
- `HAZARD_PERF_EN` defined: three 32-bit counters, reset to 0, each saturating at 0xFFFFFFFF.
  - `PerfLdStall` +1 per cycle with ldrStall & !memStall.
  - `PerfMemStall` +1 per memStall cycle.
  - `PerfFlush` +1 per cycle with `FlushD` & !reset.
- Undefined: counters and ports absent. Hazard behaviour is identical either way.

## Test plan
- Forwarding priority, NUM_SRC=3: `RA_E`={R2,R3,R15}, `WA_M`=R3 and `WA_W`=R3 both writing, `WA_W`=R2 → `ForwardE` = {00,10,01} (op2, op1, op0); `WA_M`=R15 writing → op2 stays 00.
- Load-use: `MemtoRegE`=1, `WA_E`=R4, `RA_D` op1=R4 → `StallF`=`StallD`=`FlushE`=1 for one cycle; same with `RA_D`=R15 and `WA_E`=R15 → no stall.
- `MEM_LAT`=4, single `MemReqM` held 4 cycles → stalls+`FlushW` high cycles 0–2, low cycle 3; back-to-back second request → cycles 4–6 stalled.
- `MEM_LAT`=3, `BranchTakenE`=1 during memStall → `FlushD`=`FlushE`=0 while stalled, both 1 in DONE cycle.
- Reset asserted in WAIT (`MEM_LAT`=5) → stalls 0, flushes 1 during reset; after release with `MemReqM`=1, full 4-cycle stall restarts.
- `HAZARD_PERF_EN`, `MEM_LAT`=3: one load-use stall plus one memory access → `PerfLdStall`=1, `PerfMemStall`=2; preloaded saturation holds at 0xFFFFFFFF.
